ir_block_fetcher: RTL and testbench

//  Upstream feeder of the IR-queue controller. On a load request it reads BLOCK_DEPTH

---
 rtl/ir_block_fetcher.sv | 131 +++++++++++++
 tb/tb_ir_block_fetcher.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_block_fetcher.sv
// ============================================================================
// Module   : ir_block_fetcher
// Brief    : Fetches BLOCK_DEPTH consecutive instruction words over a req/ack
//            memory port and holds them as one flat block until taken.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ir_block_fetcher #(
  parameter int IR_WIDTH    = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_load_req,
  input  logic [ADDR_WIDTH-1:0]           i_load_addr,
  output logic                            o_busy,
  output logic                            o_mem_req,
  output logic [ADDR_WIDTH-1:0]           o_mem_addr,
  input  logic                            i_mem_ack,
  input  logic [IR_WIDTH-1:0]             i_mem_data,
  output logic                            o_block_valid,
  input  logic                            i_block_taken,
  output logic [IR_WIDTH*BLOCK_DEPTH-1:0] o_ir_block,
  output logic [ADDR_WIDTH-1:0]           o_block_addr
);

  localparam int CNT_W = $clog2(BLOCK_DEPTH) + 1;
  localparam int BLK_W = IR_WIDTH * BLOCK_DEPTH;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BLOCK_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e                state_q,       state_d;
  logic                  busy_q,        busy_d;
  logic                  mem_req_q,     mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,    mem_addr_d;
  logic                  block_valid_q, block_valid_d;
  logic [BLK_W-1:0]      ir_block_q,    ir_block_d;
  logic [ADDR_WIDTH-1:0] block_addr_q,  block_addr_d;
  logic [CNT_W-1:0]      cnt_q,         cnt_d;

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    block_valid_d = block_valid_q;
    ir_block_d    = ir_block_q;
    block_addr_d  = block_addr_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      ST_IDLE, ST_HOLD: begin
        // A new load from HOLD wins over a simultaneous take.
        if (i_load_req) begin
          state_d       = ST_FETCH;
          mem_addr_d    = i_load_addr;
          block_addr_d  = i_load_addr;
          ir_block_d    = '0;
          cnt_d         = '0;
          mem_req_d     = 1'b1;
          busy_d        = 1'b1;
          block_valid_d = 1'b0;
        end else if (state_q == ST_HOLD && i_block_taken) begin
          state_d       = ST_IDLE;
          block_valid_d = 1'b0;
        end
      end

      ST_FETCH: begin
        if (i_mem_ack && mem_req_q) begin
          for (int k = 0; k < BLOCK_DEPTH; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              ir_block_d[k*IR_WIDTH +: IR_WIDTH] = i_mem_data;
            end
          end
          cnt_d      = cnt_q + CNT_W'(1);
          mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
          if (cnt_q == C_LAST) begin
            state_d       = ST_HOLD;
            mem_req_d     = 1'b0;
            busy_d        = 1'b0;
            block_valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      block_valid_q <= 1'b0;
      ir_block_q    <= '0;
      block_addr_q  <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      block_valid_q <= block_valid_d;
      ir_block_q    <= ir_block_d;
      block_addr_q  <= block_addr_d;
      cnt_q         <= cnt_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_mem_req     = mem_req_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_block_valid = block_valid_q;
  assign o_ir_block    = ir_block_q;
  assign o_block_addr  = block_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_ir_block_fetcher.sv
// ============================================================================
// Module   : tb_ir_block_fetcher
// Brief    : Directed scoreboard bench for ir_block_fetcher.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ir_block_fetcher;

  localparam int IR_WIDTH    = 8;
  localparam int ADDR_WIDTH  = 16;
  localparam int BLOCK_DEPTH = 8;
  localparam int BLK_W       = IR_WIDTH * BLOCK_DEPTH;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  i_load_req = 1'b0;
  logic [ADDR_WIDTH-1:0] i_load_addr = '0;
  logic                  o_busy;
  logic                  o_mem_req;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  i_mem_ack = 1'b0;
  logic [IR_WIDTH-1:0]   i_mem_data = '0;
  logic                  o_block_valid;
  logic                  i_block_taken = 1'b0;
  logic [BLK_W-1:0]      o_ir_block;
  logic [ADDR_WIDTH-1:0] o_block_addr;

  ir_block_fetcher #(
    .IR_WIDTH   (IR_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BLOCK_DEPTH(BLOCK_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_load_req   (i_load_req),
    .i_load_addr  (i_load_addr),
    .o_busy       (o_busy),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .i_mem_ack    (i_mem_ack),
    .i_mem_data   (i_mem_data),
    .o_block_valid(o_block_valid),
    .i_block_taken(i_block_taken),
    .o_ir_block   (o_ir_block),
    .o_block_addr (o_block_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [BLK_W-1:0]      blk;
  } exp_t;

  exp_t             sb[$];
  int               errors = 0;
  int               checks = 0;
  logic [BLK_W-1:0] last_blk;
  logic [ADDR_WIDTH-1:0] last_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory contents: mem[a] = a[7:0]
  function automatic logic [BLK_W-1:0] model_block(input logic [ADDR_WIDTH-1:0] a);
    logic [BLK_W-1:0]      b;
    logic [ADDR_WIDTH-1:0] ak;
    b = '0;
    for (int k = 0; k < BLOCK_DEPTH; k++) begin
      ak = a + ADDR_WIDTH'(k);
      b[k*IR_WIDTH +: IR_WIDTH] = ak[7:0];
    end
    return b;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"},  64'(o_busy), 64'd0);
    chk({tag, "_req"},   64'(o_mem_req), 64'd0);
    chk({tag, "_addr"},  64'(o_mem_addr), 64'd0);
    chk({tag, "_valid"}, 64'(o_block_valid), 64'd0);
    chk({tag, "_block"}, 64'(o_ir_block), 64'd0);
    chk({tag, "_baddr"}, 64'(o_block_addr), 64'd0);
  endtask

  // Drive a load (optionally with taken) for one edge and push the expected block.
  task automatic start_load(input logic [ADDR_WIDTH-1:0] a, input logic taken);
    exp_t e;
    e.addr = a;
    e.blk  = model_block(a);
    sb.push_back(e);
    i_load_req    = 1'b1;
    i_load_addr   = a;
    i_block_taken = taken;
    tick();
    i_load_req    = 1'b0;
    i_block_taken = 1'b0;
    i_load_addr   = 16'h5555;
    chk("start_busy",  64'(o_busy), 64'd1);
    chk("start_req",   64'(o_mem_req), 64'd1);
    chk("start_addr",  64'(o_mem_addr), 64'(a));
    chk("start_valid", 64'(o_block_valid), 64'd0);
    chk("start_block", 64'(o_ir_block), 64'd0);
    chk("start_baddr", 64'(o_block_addr), 64'(a));
  endtask

  // mode 0: ack tied high; mode 1: ack pattern 1,0,0,1,0,0,...
  // n_words < BLOCK_DEPTH stops early (for the mid-fetch reset case).
  task automatic run_fetch(input logic [ADDR_WIDTH-1:0] a, input int mode,
                           input logic extra_load, input int n_words);
    int k   = 0;
    int cyc = 0;
    logic [ADDR_WIDTH-1:0] ak;
    exp_t e;
    while (k < n_words && cyc < 200) begin
      ak = a + ADDR_WIDTH'(k);
      chk("fetch_addr",  64'(o_mem_addr), 64'(ak));
      chk("fetch_req",   64'(o_mem_req), 64'd1);
      chk("fetch_valid", 64'(o_block_valid), 64'd0);
      i_mem_ack  = (mode == 0) || (cyc % 3 == 0);
      i_mem_data = i_mem_ack ? ak[7:0] : 8'hEE;
      if (extra_load) begin
        i_load_req  = 1'b1;
        i_load_addr = 16'h0900;
      end
      tick();
      if (i_mem_ack) k++;
      cyc++;
    end
    i_mem_ack  = 1'b0;
    i_mem_data = '0;
    i_load_req = 1'b0;
    chk("fetch_timeout", 64'(k), 64'(n_words));
    if (n_words == BLOCK_DEPTH) begin
      if (mode == 0) chk("latency", 64'(cyc), 64'(BLOCK_DEPTH));
      chk("done_valid", 64'(o_block_valid), 64'd1);
      chk("done_busy",  64'(o_busy), 64'd0);
      chk("done_req",   64'(o_mem_req), 64'd0);
      if (sb.size() == 0) begin
        chk("sb_empty", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("block",      64'(o_ir_block), 64'(e.blk));
        chk("block_addr", 64'(o_block_addr), 64'(e.addr));
        last_blk  = e.blk;
        last_addr = e.addr;
      end
    end
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();
    check_reset_vals("idle");

    // 1: ack tied high, block at 0x0100
    start_load(16'h0100, 1'b0);
    run_fetch(16'h0100, 0, 1'b0, BLOCK_DEPTH);
    chk("t1_literal", 64'(o_ir_block), 64'h0706050403020100);

    // 6: hold 20 cycles without taken, then take
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_valid", 64'(o_block_valid), 64'd1);
      chk("hold_block", 64'(o_ir_block), 64'(last_blk));
    end
    chk("hold_baddr", 64'(o_block_addr), 64'(last_addr));
    i_block_taken = 1'b1;
    tick();
    i_block_taken = 1'b0;
    chk("taken_valid", 64'(o_block_valid), 64'd0);
    chk("taken_busy",  64'(o_busy), 64'd0);

    // Taken and ack in IDLE are ignored
    i_block_taken = 1'b1;
    i_mem_ack     = 1'b1;
    i_mem_data    = 8'h77;
    tick();
    i_block_taken = 1'b0;
    i_mem_ack     = 1'b0;
    chk("idle_req",   64'(o_mem_req), 64'd0);
    chk("idle_valid", 64'(o_block_valid), 64'd0);
    chk("idle_block", 64'(o_ir_block), 64'(last_blk));
    chk("idle_addr",  64'(o_mem_addr), 64'(16'h0108));

    // 2: stalled acks
    start_load(16'h0300, 1'b0);
    run_fetch(16'h0300, 1, 1'b0, BLOCK_DEPTH);

    // 3: address wrap
    start_load(16'hFFFC, 1'b0);
    run_fetch(16'hFFFC, 0, 1'b0, BLOCK_DEPTH);
    chk("wrap_block", 64'(o_ir_block), 64'h03020100FFFEFDFC);

    // 4: taken + load on the same edge from HOLD; extra load_req in FETCH ignored
    start_load(16'h0200, 1'b1);
    run_fetch(16'h0200, 0, 1'b1, BLOCK_DEPTH);
    i_load_req = 1'b1;
    i_load_addr = 16'h0600;
    sb.push_back('{addr: 16'h0600, blk: model_block(16'h0600)});
    tick();
    i_load_req = 1'b0;
    chk("reload_valid", 64'(o_block_valid), 64'd0);
    chk("reload_addr",  64'(o_mem_addr), 64'(16'h0600));
    run_fetch(16'h0600, 1, 1'b0, BLOCK_DEPTH);
    i_block_taken = 1'b1;
    tick();
    i_block_taken = 1'b0;

    // 5: reset after the 3rd ack
    start_load(16'h0400, 1'b0);
    run_fetch(16'h0400, 0, 1'b0, 3);
    void'(sb.pop_front());
    rst = 1'b1;
    tick();
    check_reset_vals("midreset");
    rst = 1'b0;
    tick();
    check_reset_vals("postreset");
    start_load(16'h0500, 1'b0);
    run_fetch(16'h0500, 0, 1'b0, BLOCK_DEPTH);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
